// File: rtl/accum_arbiter.sv
// Round-robin arbiter granting four requesters exclusive bursts into one shared accumulator.
// Define ACCUM_ARBITER_SATURATE_EN for clamping addition; the default build wraps modulo 2^WIDTH.
module accum_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [15:0]      len,
  output logic [3:0]       gnt,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_id,
  output logic [1:0]       state_o
);

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Handshakes: a beat moves on a rising edge where in_valid && in_ready; a result
  // moves where res_valid && res_ready. Valid stays high with stable payload until taken.

  state_e           state_q;
  logic [3:0]       gnt_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [1:0]       res_id_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [3:0]       count_q;
  logic [3:0]       limit_q;
  logic [1:0]       last_id_q;

  logic             win_found;
  logic [1:0]       win_id;
  logic [1:0]       cand;
  logic [WIDTH:0]   add_full;

  // Search starts one past the last served requester so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_id_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign add_full = {1'b0, sum_q} + {1'b0, in_data};

`ifdef ACCUM_ARBITER_SATURATE_EN
  assign sum_d = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
`else
  assign sum_d = add_full[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 4'd0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 2'd0;
      sum_q       <= '0;
      count_q     <= 4'd0;
      limit_q     <= 4'd0;
      last_id_q   <= 2'd3;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q    <= ACCUM;
            gnt_q      <= 4'b0001 << win_id;
            in_ready_q <= 1'b1;
            res_id_q   <= win_id;
            limit_q    <= len[4*win_id +: 4];
            sum_q      <= '0;
            count_q    <= 4'd0;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            sum_q <= sum_d;
            if (count_q == limit_q) begin
              state_q     <= DONE;
              gnt_q       <= 4'd0;
              in_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              res_data_q  <= sum_d;
            end else begin
              count_q <= count_q + 4'd1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            last_id_q   <= res_id_q;
          end
        end
        default: begin
          state_q    <= IDLE;
          gnt_q      <= 4'd0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign state_o   = state_q;

endmodule
